// File: rtl/ucdp_sync_filter.sv
// Glitch filter and edge detector for an already-synchronized level signal.
// Optional rejected-glitch counter enabled by defining UCDP_SYNC_FILTER_GLITCH_CNT_EN.
module ucdp_sync_filter #(
  parameter int unsigned CNT_WIDTH = 4,
  parameter logic        RST_VAL   = 1'b0
) (
  input  logic                 tgt_clk_i,
  input  logic                 tgt_rst_an_i,
  input  logic                 d_i,
  input  logic [CNT_WIDTH-1:0] thresh_i,
  output logic                 q_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 busy_o,
  output logic [7:0]           glitch_cnt_o,
  input  logic                 glitch_clr_i
);

  typedef enum logic [0:0] {
    StIdle,
    StQual
  } state_e;

  state_e               r_state;
  state_e               w_state_d;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_d;
  logic                 r_q;
  logic                 w_q_d;
  logic                 r_rise;
  logic                 w_rise_d;
  logic                 r_fall;
  logic                 w_fall_d;
  logic                 r_busy;
  logic                 w_busy_d;
  logic                 w_diff;
  logic                 w_accept;
  logic                 w_glitch;

  assign w_diff = d_i ^ r_q;

  // State register and registered outputs.
  always_ff @(posedge tgt_clk_i or negedge tgt_rst_an_i) begin
    if (!tgt_rst_an_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_q     <= RST_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_q     <= w_q_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
      r_busy  <= w_busy_d;
    end
  end

  // Next-state logic. The >= test tolerates thresh_i being lowered mid-qualification
  // and keeps the counter from ever wrapping.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    w_glitch  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_diff) begin
          if (thresh_i == '0) begin
            w_accept = 1'b1;
          end else begin
            w_state_d = StQual;
            w_cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      StQual: begin
        if (w_diff) begin
          if (r_cnt >= thresh_i) begin
            w_accept  = 1'b1;
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + CNT_WIDTH'(1);
          end
        end else begin
          w_glitch  = 1'b1;
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Output logic, evaluated as next values of the output registers.
  always_comb begin
    w_q_d    = r_q;
    w_rise_d = 1'b0;
    w_fall_d = 1'b0;
    w_busy_d = (w_state_d == StQual);
    if (w_accept) begin
      w_q_d    = d_i;
      w_rise_d = d_i;
      w_fall_d = ~d_i;
    end
  end

  assign q_o    = r_q;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign busy_o = r_busy;

`ifdef UCDP_SYNC_FILTER_GLITCH_CNT_EN
  logic [7:0] r_glitch_cnt;

  // Saturating counter; clear wins over a coincident glitch.
  always_ff @(posedge tgt_clk_i or negedge tgt_rst_an_i) begin
    if (!tgt_rst_an_i) begin
      r_glitch_cnt <= 8'd0;
    end else if (glitch_clr_i) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch && (r_glitch_cnt != 8'hff)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign glitch_cnt_o = r_glitch_cnt;
`else
  logic w_unused_glitch;

  assign w_unused_glitch = glitch_clr_i ^ w_glitch;
  assign glitch_cnt_o    = 8'd0;
`endif

endmodule

// File: tb/tb_ucdp_sync_filter.sv
// Scoreboard bench for ucdp_sync_filter: a stability-run model predicts every cycle's
// outputs, a negedge monitor compares them against the DUT.
module tb_ucdp_sync_filter;

  localparam int unsigned CW = 4;

  logic          tgt_clk_i;
  logic          tgt_rst_an_i;
  logic          d_i;
  logic [CW-1:0] thresh_i;
  logic          q_o;
  logic          rise_o;
  logic          fall_o;
  logic          busy_o;
  logic [7:0]    glitch_cnt_o;
  logic          glitch_clr_i;

  ucdp_sync_filter #(
    .CNT_WIDTH(CW),
    .RST_VAL  (1'b0)
  ) dut (
    .tgt_clk_i   (tgt_clk_i),
    .tgt_rst_an_i(tgt_rst_an_i),
    .d_i         (d_i),
    .thresh_i    (thresh_i),
    .q_o         (q_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .busy_o      (busy_o),
    .glitch_cnt_o(glitch_cnt_o),
    .glitch_clr_i(glitch_clr_i)
  );

  initial tgt_clk_i = 1'b0;
  always #5 tgt_clk_i = ~tgt_clk_i;

  typedef struct packed {
    logic       q;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] gcnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the level only moves once it has differed for thresh+1 cycles in a row.
  logic m_q;
  int   m_run;   // consecutive prior cycles in which d differed from the filtered level
  int   m_gcnt;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge tgt_clk_i) begin
    exp_t e;
    if (!tgt_rst_an_i) begin
      chk("reset_q", {7'd0, q_o}, 8'd0);
      chk("reset_rise", {7'd0, rise_o}, 8'd0);
      chk("reset_fall", {7'd0, fall_o}, 8'd0);
      chk("reset_busy", {7'd0, busy_o}, 8'd0);
      chk("reset_gcnt", glitch_cnt_o, 8'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("q", {7'd0, q_o}, {7'd0, e.q});
      chk("rise", {7'd0, rise_o}, {7'd0, e.rise});
      chk("fall", {7'd0, fall_o}, {7'd0, e.fall});
      chk("busy", {7'd0, busy_o}, {7'd0, e.busy});
      chk("glitch_cnt", glitch_cnt_o, e.gcnt);
    end
  end

  task automatic model_reset();
    m_q    = 1'b0;
    m_run  = 0;
    m_gcnt = 0;
  endtask

  // Apply inputs, let one edge pass, then push what the outputs must be after it.
  task automatic step(input logic d, input logic [CW-1:0] th, input logic clr);
    exp_t e;
    logic glitch;
    d_i          = d;
    thresh_i     = th;
    glitch_clr_i = clr;
    @(posedge tgt_clk_i);
    e      = '0;
    glitch = 1'b0;
    if (d != m_q) begin
      if (m_run + 1 >= int'(th) + 1) begin
        m_q    = d;
        m_run  = 0;
        e.rise = d;
        e.fall = ~d;
      end else begin
        m_run++;
      end
    end else begin
      glitch = (m_run > 0);
      m_run  = 0;
    end
`ifdef UCDP_SYNC_FILTER_GLITCH_CNT_EN
    if (clr) m_gcnt = 0;
    else if (glitch && m_gcnt < 255) m_gcnt++;
`else
    m_gcnt = 0;
`endif
    e.q    = m_q;
    e.busy = (m_run > 0);
    e.gcnt = 8'(m_gcnt);
    exp_q.push_back(e);
    #1;
  endtask

  // Assert reset just after a compare, hold it across a few compares, release mid-cycle.
  task automatic do_reset(input int cycles);
    @(negedge tgt_clk_i);
    #1;
    tgt_rst_an_i = 1'b0;
    model_reset();
    repeat (cycles) @(negedge tgt_clk_i);
    #2;
    tgt_rst_an_i = 1'b1;
  endtask

  initial begin
    logic          rd;
    logic [CW-1:0] rth;
    tgt_rst_an_i = 1'b0;
    d_i          = 1'b0;
    thresh_i     = '0;
    glitch_clr_i = 1'b0;
    model_reset();
    repeat (2) @(negedge tgt_clk_i);
    #2;
    tgt_rst_an_i = 1'b1;

    // Basic qualification, thresh 3.
    repeat (2) step(1'b0, CW'(3), 1'b0);
    repeat (6) step(1'b1, CW'(3), 1'b0);
    // Three-cycle glitch back to 1's complement level.
    repeat (3) step(1'b0, CW'(3), 1'b0);
    repeat (3) step(1'b1, CW'(3), 1'b0);
    repeat (5) step(1'b0, CW'(3), 1'b0);
    // Zero threshold, toggling every cycle.
    for (int i = 0; i < 10; i++) step(i[0], CW'(0), 1'b0);
    step(1'b0, CW'(0), 1'b0);
    // Threshold lowered mid-qualification.
    repeat (5) step(1'b1, CW'(10), 1'b0);
    repeat (3) step(1'b1, CW'(2), 1'b0);
    // Reset during qualification, then requalify from scratch.
    repeat (2) step(1'b0, CW'(0), 1'b0);
    repeat (2) step(1'b1, CW'(5), 1'b0);
    do_reset(2);
    repeat (8) step(1'b1, CW'(5), 1'b0);
    // Glitch counter saturation and clear-wins.
    repeat (2) step(1'b0, CW'(0), 1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, CW'(3), 1'b0);
      step(1'b0, CW'(3), 1'b0);
    end
    step(1'b1, CW'(3), 1'b0);
    step(1'b0, CW'(3), 1'b1);
    step(1'b0, CW'(3), 1'b0);

    // Random phase: sticky level with occasional flips, slowly varying threshold.
    rd  = 1'b0;
    rth = CW'($urandom_range(0, 6));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      if ($urandom_range(0, 63) == 0) rth = CW'($urandom_range(0, (1 << CW) - 1));
      step(rd, rth, ($urandom_range(0, 31) == 0));
      if ($urandom_range(0, 999) == 0) do_reset(1);
    end

    repeat (2) @(negedge tgt_clk_i);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ucdp_sync_filter.md
Name: ucdp_sync_filter

Overview:
Glitch filter and edge detector for a single level signal that has already been synchronized into the target clock domain. It sits directly downstream of the zero-reset two-flop synchronizer leaf; its d_i is driven by that leaf's q_o. A level change is accepted only after it has been stable for a programmable number of cycles. The block then emits a registered filtered level and one-cycle rise/fall pulses for target-domain consumers such as IRQ and wakeup logic.

Parameters:
- CNT_WIDTH, default 4: width of the qualification counter and of thresh_i (1..16).
- RST_VAL, default 1'b0: reset value of q_o. Matches the zero-reset synchronizer leaf.

Ports:
- tgt_clk_i  input  1  target clock
- tgt_rst_an_i  input  1  Async Reset (Low-Active)
- d_i  input  1  synchronized level, driven by the synchronizer leaf's q_o
- thresh_i  input  CNT_WIDTH  stability threshold: the new level must hold thresh_i+1 consecutive cycles
- q_o  output  1  filtered level
- rise_o  output  1  one-cycle pulse on each accepted 0->1 change
- fall_o  output  1  one-cycle pulse on each accepted 1->0 change
- busy_o  output  1  a qualification is in progress
- glitch_cnt_o  output  8  count of rejected glitches (optional feature)
- glitch_clr_i  input  1  synchronous clear of glitch_cnt_o (optional feature)

Behaviour:
- Reset (async, tgt_rst_an_i low):
  - q_o=RST_VAL; rise_o=0; fall_o=0; busy_o=0; glitch_cnt_o=0.
  - Counter cleared; state IDLE.
  - Reset assertion mid-qualification aborts it; no pulse is generated.
- State machine, all outputs registered:
  - IDLE: d_i==q_o. If d_i!=q_o: go to QUAL, cnt<=1, busy_o<=1. If thresh_i==0: accept immediately (see accept).
  - QUAL, d_i!=q_o:
    - If cnt>=thresh_i: accept.
    - Else cnt<=cnt+1.
    - The >= comparison covers thresh_i being lowered mid-qualification.
  - QUAL, d_i==q_o: glitch rejected; go to IDLE, cnt<=0, busy_o<=0, glitch event.
- Accept: on the same edge, q_o<=d_i and cnt<=0, go to IDLE, busy_o<=0. Set rise_o<=d_i, fall_o<=~d_i, each for exactly one cycle.
- Latency:
  - First cycle d_i differs from q_o is cycle 0. q_o and pulse change after edge thresh_i, i.e. visible in cycle thresh_i+1.
  - thresh_i==0 gives a single register stage, latency 1.
- Pulse rules:
  - rise_o and fall_o are never high together.
  - rise_o/fall_o are high only in the cycle where q_o changes.
- Counter: cnt never exceeds 2^CNT_WIDTH-1; no wrap-around is possible because acceptance occurs at cnt>=thresh_i.
- thresh_i is sampled every cycle; it must be quasi-static, since changes take effect immediately.
- Back-to-back: a new opposite change may begin qualifying in the cycle after accept.

Optional Feature:
- Macro: UCDP_SYNC_FILTER_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt_o is an 8-bit counter that increments on each glitch-rejected event and saturates at 255.
  - glitch_clr_i=1 clears it to 0 on the next edge; clear wins over a simultaneous increment.
- Not defined:
  - glitch_cnt_o is tied to 8'd0; glitch_clr_i is unused.
  - No counter flops are inferred.

Test Plan:
1. Reset, thresh_i=3, d_i 0->1 held: q_o=1 and rise_o=1 for one cycle, 4 cycles after the first d_i=1 sample; busy_o=1 for cycles 1..3.
2. thresh_i=3, d_i=1 pulse for 3 cycles, then back to 0: q_o stays 0, no pulses, busy_o returns 0; glitch_cnt_o=1 with UCDP_SYNC_FILTER_GLITCH_CNT_EN, otherwise 0.
3. thresh_i=0, d_i toggles every cycle: q_o follows d_i with 1-cycle delay; rise_o/fall_o alternate each cycle, never both high.
4. thresh_i=10, d_i=1 held; after 5 cycles thresh_i changes to 2: accept on the next edge, rise_o pulse; q_o=1.
5. Reset asserted during QUAL (cnt=2, thresh_i=5): all outputs return to reset values immediately; after release with d_i still 1, qualification restarts from 0, rise_o after 6 cycles.
6. With UCDP_SYNC_FILTER_GLITCH_CNT_EN, 300 glitches: glitch_cnt_o saturates at 255. Assert glitch_clr_i together with a glitch: glitch_cnt_o=0.
